// File: rtl/memory_cycle.sv
// Memory (M) stage of the 19-bit CPU: word-addressed data memory, load/ALU result
// select, M/W pipeline register and a sticky out-of-range access flag.
module memory_cycle #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] aluresultM,
    input  logic [18:0] writedataM,
    input  logic [2:0]  rdM,
    input  logic        regwriteM,
    input  logic        resultsrcM,
    input  logic        memwriteM,
    output logic [18:0] resultW,
    output logic [2:0]  rdW,
    output logic        regwriteW,
    output logic [18:0] fwd_dataM,
    output logic        addr_fault
);

    logic [18:0]       mem [DEPTH];
    logic              in_range;
    logic [ADDR_W-1:0] index;
    logic [18:0]       readdata;
    logic [18:0]       resultM;
    logic              mem_access;

    // Compare in 20 bits so DEPTH = 2^19 does not wrap to zero.
    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        in_range   = 1'b0;
        index      = '0;
        readdata   = '0;
        resultM    = '0;
        mem_access = 1'b0;

        in_range   = ({1'b0, aluresultM} < 20'(DEPTH));
        index      = aluresultM[ADDR_W-1:0];
        mem_access = memwriteM || resultsrcM;

        if (in_range) begin
            readdata = mem[index];
        end
        resultM = resultsrcM ? readdata : aluresultM;
    end

    assign fwd_dataM = aluresultM;

    // The combinational read above sees the pre-edge contents, so a same-cycle
    // store to the read index yields the old word.
    // NOTE: the memory is cleared by reset here because the architecture requires
    // it; this forces a register array rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (memwriteM && in_range) begin
            mem[index] <= writedataM;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resultW   <= '0;
            rdW       <= '0;
            regwriteW <= 1'b0;
        end else begin
            resultW   <= resultM;
            rdW       <= rdM;
            regwriteW <= regwriteM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_fault <= 1'b0;
        end else if (!in_range && mem_access) begin
            addr_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: stimulus pushes expected M/W results,
// a monitor pops and compares them one cycle after each issue.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] aluresultM;
    logic [18:0] writedataM;
    logic [2:0]  rdM;
    logic        regwriteM;
    logic        resultsrcM;
    logic        memwriteM;
    logic [18:0] resultW;
    logic [2:0]  rdW;
    logic        regwriteW;
    logic [18:0] fwd_dataM;
    logic        addr_fault;

    typedef struct {
        string       tag;
        logic [18:0] res;
        logic [2:0]  rd;
        logic        rw;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    memory_cycle #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluresultM (aluresultM),
        .writedataM (writedataM),
        .rdM        (rdM),
        .regwriteM  (regwriteM),
        .resultsrcM (resultsrcM),
        .memwriteM  (memwriteM),
        .resultW    (resultW),
        .rdW        (rdW),
        .regwriteW  (regwriteW),
        .fwd_dataM  (fwd_dataM),
        .addr_fault (addr_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%05h, expected 0x%05h", name, act, req);
        end
    endtask

    // One instruction per cycle: drive at negedge, queue what the M/W register
    // must hold after the following posedge.
    task automatic issue(input string tag, input logic r, input logic [18:0] a,
                         input logic [18:0] wd, input logic [2:0] rd, input logic rw,
                         input logic src, input logic mw, input logic [18:0] e_res,
                         input logic [2:0] e_rd, input logic e_rw, input logic e_flt);
        exp_t e;
        @(negedge clk);
        rst        = r;
        aluresultM = a;
        writedataM = wd;
        rdM        = rd;
        regwriteM  = rw;
        resultsrcM = src;
        memwriteM  = mw;
        e.tag = tag; e.res = e_res; e.rd = e_rd; e.rw = e_rw; e.fault = e_flt;
        sb.push_back(e);
        #1;
        check({tag, ".fwd"}, fwd_dataM, a);
    endtask

    // Monitor: every result cycle, compare the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, ".resultW"},   resultW,            e.res);
                check({e.tag, ".rdW"},       19'(rdW),           19'(e.rd));
                check({e.tag, ".regwriteW"}, 19'(regwriteW),     19'(e.rw));
                check({e.tag, ".addr_fault"}, 19'(addr_fault),   19'(e.fault));
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b0; aluresultM = '0; writedataM = '0; rdM = '0;
        regwriteM = 1'b0; resultsrcM = 1'b0; memwriteM = 1'b0;

        //     tag          rst addr      wdata     rd rw src mw  e_res     e_rd rw flt
        issue("rst0",       0, 19'd3,    19'h01234, 0, 0, 0, 1, 19'h00000, 0, 0, 0);
        issue("rst1",       0, 19'd3,    19'h01234, 0, 0, 0, 1, 19'h00000, 0, 0, 0);
        issue("ld3_clr",    1, 19'd3,    19'h00000, 1, 1, 1, 0, 19'h00000, 1, 1, 0);
        // store / load round trip
        issue("st5",        1, 19'd5,    19'h7FFFF, 0, 0, 0, 1, 19'h00005, 0, 0, 0);
        issue("ld5",        1, 19'd5,    19'h00000, 2, 1, 1, 0, 19'h7FFFF, 2, 1, 0);
        // large ALU result is not an access
        issue("alu40000",   1, 19'h40000, 19'h00000, 7, 1, 0, 0, 19'h40000, 7, 1, 0);
        // read-during-write returns the old word
        issue("st9a",       1, 19'd9,    19'h00011, 0, 0, 0, 1, 19'h00009, 0, 0, 0);
        issue("rdw9",       1, 19'd9,    19'h00022, 3, 1, 1, 1, 19'h00011, 3, 1, 0);
        issue("ld9",        1, 19'd9,    19'h00000, 3, 1, 1, 0, 19'h00022, 3, 1, 0);
        // back-to-back stores then loads
        for (int i = 0; i < 4; i++)
            issue("b2b_st",  1, 19'(i),  19'(i + 1), 0, 0, 0, 1, 19'(i),    0, 0, 0);
        for (int i = 0; i < 4; i++)
            issue("b2b_ld",  1, 19'(i),  19'h00000, 4, 1, 1, 0, 19'(i + 1), 4, 1, 0);
        // last in-range word
        issue("st63",       1, 19'd63,   19'h00005, 0, 0, 0, 1, 19'd63,    0, 0, 0);
        issue("ld63",       1, 19'd63,   19'h00000, 6, 1, 1, 0, 19'h00005, 6, 1, 0);
        // out of range: addr 64 aliases index 0, which must stay 1
        issue("st64",       1, 19'd64,   19'h00AAA, 0, 0, 0, 1, 19'd64,    0, 0, 1);
        issue("ld64",       1, 19'd64,   19'h00000, 5, 1, 1, 0, 19'h00000, 5, 1, 1);
        issue("ld0_keep",   1, 19'd0,    19'h00000, 5, 1, 1, 0, 19'h00001, 5, 1, 1);
        issue("alu_sticky", 1, 19'h7FFFF, 19'h00000, 1, 1, 0, 0, 19'h7FFFF, 1, 1, 1);
        // reset clears fault and memory
        issue("rst2",       0, 19'd3,    19'h00000, 2, 1, 1, 0, 19'h00000, 0, 0, 0);
        issue("ld3_rst2",   1, 19'd3,    19'h00000, 2, 1, 1, 0, 19'h00000, 2, 1, 0);

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
